// File: rtl/clocked_latch_dff_if.sv
// clocked_latch_dff_if: data and status signals of the storage primitive bank
interface clocked_latch_dff_if #(parameter int WIDTH = 1);
  logic             sr_set_n;
  logic             sr_reset_n;
  logic             sr_q;
  logic             sr_q_b;
  logic [WIDTH-1:0] dl_d;
  logic [WIDTH-1:0] dl_q;
  logic [WIDTH-1:0] dl_q_b;
  logic [WIDTH-1:0] ff_d;
  logic [WIDTH-1:0] ff_q;
  modport master (
    output sr_set_n, sr_reset_n, dl_d, ff_d,
    input  sr_q, sr_q_b, dl_q, dl_q_b, ff_q
  );
  modport slave (
    input  sr_set_n, sr_reset_n, dl_d, ff_d,
    output sr_q, sr_q_b, dl_q, dl_q_b, ff_q
  );
endinterface

// File: rtl/clocked_latch_dff.sv
// clocked_latch_dff: clocked SR latch, clocked D latch and rising-edge DFF with shared async active-low clear
module clocked_latch_dff #(
  parameter int WIDTH = 1
) (
  input logic                clk,
  input logic                reset,
  clocked_latch_dff_if.slave bus
);
  logic             r_sr_q;
  logic [WIDTH-1:0] r_dl_q;
  logic [WIDTH-1:0] r_ff_q;
  logic             w_sr_req;
  assign w_sr_req = !(bus.sr_set_n && bus.sr_reset_n);
  // SR latch: transparent while clk is high, set wins when both requests are active
  always_latch
    if (!reset) r_sr_q <= 1'b0;
    else if (clk && w_sr_req) r_sr_q <= !bus.sr_set_n;
  // D latch: follows dl_d while clk is high, holds the falling-edge value while low
  always_latch
    if (!reset) r_dl_q <= '0;
    else if (clk) r_dl_q <= bus.dl_d;
  // DFF: captures ff_d on the rising edge, cleared immediately by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ff_q <= '0;
    else r_ff_q <= bus.ff_d;
  assign bus.sr_q   = r_sr_q;
  assign bus.sr_q_b = ~r_sr_q;
  assign bus.dl_q   = r_dl_q;
  assign bus.dl_q_b = ~r_dl_q;
  assign bus.ff_q   = r_ff_q;
endmodule

// File: tb/tb_clocked_latch_dff.sv
// tb_clocked_latch_dff: vector table plus DFF scoreboard and hand-written latch/reset sequences
module tb_clocked_latch_dff;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];
  typedef struct {
    logic         s_n;
    logic         r_n;
    logic [W-1:0] dl;
    logic [W-1:0] ff;
    logic         e_sr;
  } vec_t;
  vec_t tbl[8];
  clocked_latch_dff_if #(.WIDTH(W)) bus ();
  clocked_latch_dff #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic e_sr, input logic [W-1:0] e_dl, input logic [W-1:0] e_ff);
    logic e_sr_b;
    logic [W-1:0] e_dl_b;
    e_sr_b = ~e_sr;
    e_dl_b = ~e_dl;
    chk({tag, ".sr_q"}, W'(bus.sr_q), W'(e_sr));
    chk({tag, ".sr_q_b"}, W'(bus.sr_q_b), W'(e_sr_b));
    chk({tag, ".dl_q"}, bus.dl_q, e_dl);
    chk({tag, ".dl_q_b"}, bus.dl_q_b, e_dl_b);
    chk({tag, ".ff_q"}, bus.ff_q, e_ff);
  endtask
  task automatic pop_ff(output logic [W-1:0] v);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      v = 'x;
    end else v = sb_q.pop_front();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    logic [W-1:0] e_ff;
    tbl[0] = '{1'b1, 1'b1, 8'h3C, 8'h01, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 8'hFF, 8'h5A, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h0F, 8'hA5, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'hF0, 8'h80, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h01, 8'h7E, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 8'hA5, 8'h01, 1'b1};
    bus.sr_set_n = 1'b0;
    bus.sr_reset_n = 1'b1;
    bus.dl_d = '1;
    bus.ff_d = '1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1 check_all("rst_hi", 1'b0, '0, '0);
      @(negedge clk); #1 check_all("rst_lo", 1'b0, '0, '0);
    end
    #4 reset = 1'b1;
    #1 check_all("rel_lo", 1'b0, '0, '0);
    sb_q.push_back(bus.ff_d);
    @(posedge clk); #1 pop_ff(e_ff);
    check_all("rel_hi", 1'b1, '1, e_ff);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #2;
      bus.sr_set_n = tbl[i].s_n;
      bus.sr_reset_n = tbl[i].r_n;
      bus.dl_d = tbl[i].dl;
      bus.ff_d = tbl[i].ff;
      sb_q.push_back(tbl[i].ff);
      @(posedge clk); #1 pop_ff(e_ff);
      check_all($sformatf("vec%0d", i), tbl[i].e_sr, tbl[i].dl, e_ff);
    end
    @(negedge clk); #2 bus.sr_reset_n = 1'b0;
    @(posedge clk); #1 chk("sr_clear", W'(bus.sr_q), W'(1'b0));
    @(negedge clk); #2 bus.sr_reset_n = 1'b1;
    #3 bus.sr_set_n = 1'b0;
    #1 chk("set_pulse_lo", W'(bus.sr_q), W'(1'b0));
    @(posedge clk); #1 chk("set_pulse_hi", W'(bus.sr_q), W'(1'b1));
    #144 bus.sr_set_n = 1'b1;
    @(posedge clk); #1 chk("set_after", W'(bus.sr_q), W'(1'b1));
    chk("set_after_b", W'(bus.sr_q_b), W'(1'b0));
    @(negedge clk); #3 bus.sr_reset_n = 1'b0;
    #5 bus.sr_reset_n = 1'b1;
    #1 chk("glitch_lo", W'(bus.sr_q), W'(1'b1));
    @(posedge clk); #1 chk("glitch_hi", W'(bus.sr_q), W'(1'b1));
    #2 bus.dl_d = 8'hAA;
    #1 chk("dl_tr0", bus.dl_q, 8'hAA);
    chk("dl_tr0_b", bus.dl_q_b, 8'h55);
    #2 bus.dl_d = 8'h55;
    #1 chk("dl_tr1", bus.dl_q, 8'h55);
    @(negedge clk); #2 bus.dl_d = 8'h0F;
    #1 chk("dl_hold", bus.dl_q, 8'h55);
    @(posedge clk); #1 chk("dl_reopen", bus.dl_q, 8'h0F);
    @(negedge clk); #5 bus.ff_d = 8'hC3;
    #1 chk("ff_pre", bus.ff_q, 8'h01);
    @(posedge clk); #1 chk("ff_cap", bus.ff_q, 8'hC3);
    #2 bus.ff_d = 8'h3C;
    #1 chk("ff_hi_stable", bus.ff_q, 8'hC3);
    @(negedge clk); #1 chk("ff_lo_stable", bus.ff_q, 8'hC3);
    @(posedge clk); #1 chk("ff_cap2", bus.ff_q, 8'h3C);
    @(negedge clk); #5 reset = 1'b0;
    #1 check_all("async_rst", 1'b0, '0, '0);
    bus.ff_d = 8'hFF;
    @(posedge clk); #1 check_all("in_rst_hi", 1'b0, '0, '0);
    #3 bus.ff_d = 8'h81;
    @(negedge clk); #5 reset = 1'b1;
    bus.ff_d = 8'hFF;
    #1 chk("rel2_ff", bus.ff_q, 8'h00);
    @(posedge clk); #1 chk("rel2_cap", bus.ff_q, 8'hFF);
    chk("rel2_dl", bus.dl_q, 8'h0F);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/clocked_latch_dff.md
Name: clocked_latch_dff

Overview:
- Bank of three basic clocked storage elements sharing one clock and one reset:
  - a level-sensitive clocked SR latch with active-low set/reset inputs;
  - a level-sensitive clocked D latch;
  - a rising-edge D flip-flop.
- Used as the leaf storage primitive library beneath registers and sequence adders.
- Each element drives a true output; the two latches also drive a complementary output.

Parameters:
- WIDTH, default 1: bit width of the D-latch and DFF data paths. The SR latch is always 1 bit.

Ports:
- clk, input, 1: single clock. Acts as the latch enable while high and the DFF capture edge on its rising edge.
- reset, input, 1: asynchronous, active-low reset for all three elements.
- sr_set_n, input, 1: SR latch set request, active-low.
- sr_reset_n, input, 1: SR latch reset request, active-low.
- sr_q, output, 1: SR latch state.
- sr_q_b, output, 1: SR latch complement; always ~sr_q.
- dl_d, input, WIDTH: D latch data.
- dl_q, output, WIDTH: D latch state.
- dl_q_b, output, WIDTH: D latch complement; always ~dl_q.
- ff_d, input, WIDTH: DFF data.
- ff_q, output, WIDTH: DFF state.

Behaviour:
- Reset
  - reset=0 immediately forces sr_q=0, dl_q=0 and ff_q=0, without waiting for any clock; sr_q_b=1 and dl_q_b=all ones.
  - All three elements stay in reset for as long as reset=0, regardless of clk or data inputs.
  - Release of reset (0 to 1) changes no output; elements resume normal operation from the cleared state.
- SR latch (level-sensitive, transparent while clk=1)
  - clk=1, sr_set_n=0, sr_reset_n=1: sr_q=1.
  - clk=1, sr_set_n=1, sr_reset_n=0: sr_q=0.
  - clk=1, both inputs 1 (idle): hold.
  - clk=1, both inputs 0: set dominates, sr_q=1. No invalid q=q_b state is ever produced.
  - clk=0: hold, regardless of inputs. Input pulses that start and end while clk=0 are ignored.
  - A request held across the rising edge of clk takes effect as soon as clk goes high; no edge detection.
- D latch
  - clk=1: dl_q follows dl_d combinationally (transparent); every dl_d change while clk is high appears on dl_q with zero cycles of latency.
  - clk=0: dl_q holds the value present at the falling edge of clk.
- DFF
  - On each rising edge of clk with reset=1, ff_q takes the value of ff_d.
  - ff_q is otherwise stable; ff_d changes between rising edges have no effect.
  - Latency: exactly one rising edge.
- Simultaneous events
  - Reset asserted coincident with a clk rising edge: reset wins, ff_q=0.
  - Reset deasserted coincident with a clk rising edge: no capture on that edge; the first capture is on the next rising edge.
- Complement outputs are derived from the stored state, never separately stored.
- Implementation is synthesizable. Latches are coded as explicit level-sensitive storage (or cross-coupled NAND structure with the set-dominant resolution above); the DFF is edge-triggered with an asynchronous clear.
- No X is allowed on any output after the first reset assertion.

Test Plan:
- Reset: drive reset=0 with clk toggling (20 ns period), sr_set_n=0 and dl_d=ff_d=1 -> sr_q=0, sr_q_b=1, dl_q=0, dl_q_b=1, ff_q=0 throughout; release reset -> sr_q stays 0 until clk is next high.
- SR latch:
  - Idle both inputs at 1; pulse sr_set_n=0 for 150 ns -> sr_q=1 from the first clk-high phase inside the pulse, and stays 1 after the pulse ends.
  - Then pulse sr_reset_n=0 -> sr_q=0, sr_q_b=1.
  - Drive both low -> sr_q=1.
- SR latch hold: pulse sr_set_n=0 for 5 ns entirely within clk=0 -> sr_q unchanged.
- D latch:
  - Toggle dl_d 1->0->1 every 150 ns -> dl_q tracks dl_d while clk=1 and freezes at the falling-edge value while clk=0.
  - With WIDTH=8, dl_d=8'hA5 while clk=1 -> dl_q=8'hA5 and dl_q_b=8'h5A.
- DFF capture:
  - ff_d=1 set mid-low-phase -> ff_q rises exactly at the next rising edge.
  - ff_d toggled while clk=1 -> no ff_q change until the following rising edge.
- DFF async reset mid-operation: with ff_q=1, assert reset=0 between clock edges -> ff_q=0 immediately; toggling ff_d while in reset keeps ff_q=0; after release, ff_d=1 -> ff_q=1 at the next rising edge.
